// File: rtl/score_pkg.sv
// Shared constants and types for the score display controller.
// Imported by the decoder and the controller top.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    IDLE,
    ADD
  } state_t;

  function automatic logic [BCD_W-1:0] bcd_clamp(
    input logic [BCD_W-1:0] n
  );
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

endpackage

// File: rtl/score_hex_display.sv
// Hex to common-anode 7-segment decoder, active-low gfedcba.
// Code F is reserved as the blank code, so it lights nothing.
import score_pkg::*;

module score_hex_display (
  input  logic [BCD_W-1:0] hex,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score owner: serial BCD adder with saturation plus a
// multiplexed 7-segment scan with leading-zero blanking.
import score_pkg::*;

module score_display_ctrl #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    add_valid,
  input  logic [7:0]              add_bcd,
  output logic                    add_ready,
  output logic [BCD_W*DIGITS-1:0] score_bcd,
  output logic [6:0]              seg,
  output logic [DIGITS-1:0]       an
);

  localparam int KW = $clog2(DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = BCD_W*DIGITS;

  state_t state, state_n;
  logic [KW-1:0] k, k_n;
  logic carry, carry_n;
  logic [7:0] inc, inc_n;
  logic [SW-1:0] score, score_n;
  logic [SW-1:0] shadow, shadow_n;
  logic [SW-1:0] nines;
  logic [BCD_W-1:0] cur, incd, dval;
  logic [4:0] dsum;
  logic cout;
  int kk;

  assign add_ready = (state == IDLE) && !clear;
  assign score_bcd = score;

  always_comb begin
    state_n  = state;
    k_n      = k;
    carry_n  = carry;
    inc_n    = inc;
    score_n  = score;
    shadow_n = shadow;
    kk       = int'(k);
    for (int i = 0; i < DIGITS; i++)
      nines[BCD_W*i +: BCD_W] = 4'd9;
    cur  = score[BCD_W*kk +: BCD_W];
    incd = (kk == 0) ? inc[3:0] :
           (kk == 1) ? inc[7:4] : '0;
    dsum = {1'b0, cur} + {1'b0, incd} + {4'b0, carry};
    cout = (dsum > 5'd9);
    dval = cout ? 4'(dsum - 5'd10) : dsum[3:0];
    unique case (state)
      IDLE: begin
        if (clear) begin
          score_n = '0;
        end else if (add_valid) begin
          inc_n   = {bcd_clamp(add_bcd[7:4]),
                     bcd_clamp(add_bcd[3:0])};
          k_n     = '0;
          carry_n = 1'b0;
          state_n = ADD;
        end
      end
      ADD: begin
        if (clear) begin
          score_n  = '0;
          shadow_n = '0;
          state_n  = IDLE;
        end else begin
          shadow_n[BCD_W*kk +: BCD_W] = dval;
          carry_n = cout;
          if (k == KW'(DIGITS-1)) begin
            // carry out of the top digit pins the score at all nines
            score_n = cout ? nines : shadow_n;
            state_n = IDLE;
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      carry  <= 1'b0;
      inc    <= '0;
      score  <= '0;
      shadow <= '0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      carry  <= carry_n;
      inc    <= inc_n;
      score  <= score_n;
      shadow <= shadow_n;
    end
  end

  logic [CW-1:0] cnt;
  logic [KW-1:0] idx;
  logic [DIGITS-1:0] blank;
  logic zero_above;
  logic [BCD_W-1:0] hex;
  logic [6:0] seg_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(SCAN_DIV-1)) begin
      cnt <= '0;
      idx <= (idx == KW'(DIGITS-1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      zero_above = zero_above &&
                   (score[BCD_W*i +: BCD_W] == '0);
      blank[i] = (i > 0) && zero_above;
    end
    hex = blank[idx] ? BLANK_CODE :
          score[BCD_W*int'(idx) +: BCD_W];
  end

  score_hex_display u_dec (
    .hex (hex),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else begin
      seg <= seg_dec;
      an  <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: vector table, scoreboard queue
// and directed clear/reset/saturation sequences.
module tb_score_display_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic add_valid = 1'b0;
  logic [7:0] add_bcd = 8'h00;
  logic add_ready;
  logic [15:0] score_bcd;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int failures = 0;
  logic [15:0] sbq[$];
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    bit          clr;
    logic [7:0]  bcd;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  score_display_ctrl #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .add_valid (add_valid),
    .add_bcd   (add_bcd),
    .add_ready (add_ready),
    .score_bcd (score_bcd),
    .seg       (seg),
    .an        (an)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_add(
    input logic [15:0] s, input logic [7:0] b);
    int v, t, o;
    logic [15:0] r;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v*10 + int'(s[4*i +: 4]);
    t = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    o = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    v = v + t*10 + o;
    if (v > 9999) v = 9999;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(
    input logic [15:0] s, input int idx);
    logic [15:0] hi;
    hi = s >> (4*idx);
    if (idx > 0 && hi == 16'h0) return 7'h7F;
    return segtab[hi[3:0]];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (add_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic do_add(input logic [7:0] b,
                        input logic [15:0] exp);
    logic [15:0] old;
    @(negedge clk);
    wait_ready();
    old = score_bcd;
    add_valid = 1'b1;
    add_bcd = b;
    @(posedge clk);
    sbq.push_back(exp);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      add_valid = 1'b0;
      chk("busy_ready", 32'(add_ready), 0);
      chk("no_partial", 32'(score_bcd), 32'(old));
      @(posedge clk);
    end
    @(negedge clk);
    chk("sum", 32'(score_bcd), 32'(sbq.pop_front()));
    chk("ready_back", 32'(add_ready), 1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("clear_score", 32'(score_bcd), 0);
    chk("clear_blocks", 32'(add_ready), 0);
    clear = 1'b0;
    #1;
    chk("clear_ready", 32'(add_ready), 1);
  endtask

  task automatic display_check(input int n,
                               input logic [15:0] s);
    int idx;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      idx = 0;
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) idx = i;
      chk("an_onehot", 32'($countones(~an)), 1);
      chk("disp_seg", 32'(seg), 32'(exp_seg(s, idx)));
    end
  endtask

  initial begin
    int e, idx;
    logic [15:0] m;
    vecs[0] = '{1'b1, 8'h25, 16'h0025};
    vecs[1] = '{1'b1, 8'h95, 16'h0095};
    vecs[2] = '{1'b0, 8'h07, 16'h0102};
    vecs[3] = '{1'b0, 8'h99, 16'h0201};
    vecs[4] = '{1'b1, 8'hAF, 16'h0099};
    vecs[5] = '{1'b0, 8'h01, 16'h0100};

    #12;
    chk("rst_score", 32'(score_bcd), 0);
    chk("rst_ready", 32'(add_ready), 1);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    for (e = 1; e <= 32; e++) begin
      @(posedge clk);
      @(negedge clk);
      idx = ((e - 1) / 4) % 4;
      chk("scan_an", 32'(an), 32'(~(4'b1 << idx) & 4'hF));
      chk("scan_seg", 32'(seg), (idx == 0) ? 32'h40 : 32'h7F);
    end
    chk("idle_score", 32'(score_bcd), 0);

    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear();
      do_add(vecs[i].bcd, vecs[i].exp);
      display_check(20, vecs[i].exp);
    end

    do_clear();
    do_add(8'h40, 16'h0040);
    @(negedge clk);
    wait_ready();
    add_valid = 1'b1;
    add_bcd = 8'h99;
    @(posedge clk);
    @(negedge clk);
    add_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_score", 32'(score_bcd), 0);
    chk("abort_blocked", 32'(add_ready), 0);
    clear = 1'b0;
    #1;
    chk("abort_idle", 32'(add_ready), 1);
    repeat (6) @(negedge clk);
    chk("abort_lost", 32'(score_bcd), 0);

    @(negedge clk);
    clear = 1'b1;
    add_valid = 1'b1;
    add_bcd = 8'h12;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    add_valid = 1'b0;
    #1;
    chk("clr_valid_idle", 32'(add_ready), 1);
    repeat (6) @(negedge clk);
    chk("clr_valid_noacc", 32'(score_bcd), 0);

    m = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      m = model_add(m, 8'h99);
      do_add(8'h99, m);
    end
    m = model_add(m, 8'h90);
    do_add(8'h90, m);
    chk("pre_sat", 32'(score_bcd), 32'h9990);
    do_add(8'h15, model_add(m, 8'h15));
    chk("sat", 32'(score_bcd), 32'h9999);
    display_check(16, 16'h9999);

    @(negedge clk);
    wait_ready();
    add_valid = 1'b1;
    add_bcd = 8'h01;
    @(posedge clk);
    @(negedge clk);
    add_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_score", 32'(score_bcd), 0);
    chk("arst_ready", 32'(add_ready), 1);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_an", 32'(an), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_commit", 32'(score_bcd), 0);
    chk("arst_ready2", 32'(add_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Owns the player score and sequences one shared score_hex_display decoder across a multiplexed bank of common-anode 7-segment digits.
- Accepts BCD point increments from game logic over a valid/ready handshake and adds them one digit per cycle. Saturates at all-nines.
- Time-multiplexes the score digits onto the single segment bus with leading-zero blanking.
- Sits between the game-state/collision logic and the board display pins.

Parameters:
- DIGITS, 4, number of BCD score digits and display positions (2..8).
- SCAN_DIV, 50000, clk cycles each digit stays lit before the scan advances (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous score clear, level-sensitive
- add_valid  in  1  increment request
- add_bcd  in  8  increment as two BCD digits {tens,ones}
- add_ready  out  1  controller can accept an increment
- score_bcd  out  4*DIGITS  committed score, digit 0 = ones in LSBs
- seg  out  7  segment drive, active-low, gfedcba
- an  out  DIGITS  digit enables, active-low, one-hot-low

Behaviour:
- Reset values (async, rst_n=0):
  - score_bcd=0, add_ready=1, FSM=IDLE.
  - Scan counter=0, scan index=0.
  - seg=7'h7F, an=all ones.
- Handshake:
  - An increment is accepted on a rising edge where add_valid=1 and add_ready=1.
  - add_ready = (state==IDLE) and not clear.
  - add_bcd is latched at acceptance. Nibbles >9 are clamped to 9.
- FSM IDLE -> ADD on acceptance:
  - ADD holds digit index k = 0..DIGITS-1 plus a carry bit.
  - Each cycle: d = score_k + inc_k + carry, where inc_k is 0 for k>=2.
  - If d>9, write d-10 to shadow[k] and set carry=1. Otherwise write d and set carry=0.
  - On k=DIGITS-1, commit shadow to score_bcd and return to IDLE.
  - Latency: score_bcd updates exactly DIGITS cycles after the accepting edge, and add_ready is high again in the following cycle.
  - score_bcd never shows a partial sum.
- Saturation: if carry out of digit DIGITS-1 is 1, commit all digits = 9 (for DIGITS=4, 9999).
- Clear priority:
  - clear=1 in IDLE zeroes score_bcd on the next edge and blocks acceptance.
  - clear=1 in ADD aborts the add, zeroes score_bcd and shadow, and returns to IDLE. The increment is lost.
- Scan:
  - A free-running counter counts 0..SCAN_DIV-1.
  - At terminal count the scan index increments, wrapping DIGITS-1 -> 0.
  - Scan runs independently of the FSM and clear.
- Blanking: digit i is blank if i>0 and all digits i..DIGITS-1 are 0. Blank digits feed 4'hF to the decoder (all segments off). Digit 0 is never blank, so a score of 0 shows "0".
- Output timing:
  - Decoder input = selected committed digit, or 4'hF when blank.
  - seg and an are registered, one cycle after the scan index changes.
  - an drives low only the bit for the current index.
  - At reset release, the first registered update shows digit 0.

Decomposition:
- Shared package score_pkg holds:
  - BCD_W=4
  - BLANK_CODE=4'hF
  - SEG_OFF=7'h7F
  - FSM state enum {IDLE, ADD}
- One natural sub-module: the existing score_hex_display decoder, instantiated once.
- Scan counter and adder FSM stay inline.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset then release with no activity -> score_bcd=16'h0000. The an sequence 1110,1101,1011,0111 repeats, changing every 4 cycles. seg=7'b1000000 on digit 0 and 7'h7F on digits 1..3.
- add_bcd=8'h25 accepted at edge N -> add_ready=0 for edges N+1..N+4, score_bcd=16'h0025 after edge N+4, add_ready=1 after. Display shows digits 1 and 0 only.
- Score 16'h0095 plus add 8'h07 -> 16'h0102. Carry ripples across digits 0, 1 and 2.
- Score 16'h9990 plus add 8'h15 -> saturate to 16'h9999.
- clear asserted in the third cycle of ADD (score 16'h0040, add 8'h99) -> score_bcd=16'h0000, FSM IDLE, add_ready=1 once clear drops. Also clear and add_valid asserted together in IDLE -> increment not accepted.
- add_bcd=8'hAF -> treated as 8'h99. rst_n pulsed low mid-ADD -> all outputs return to reset values immediately, asynchronously.
